// File: rtl/ddr5_refresh_scheduler.sv
// ddr5_refresh_scheduler
//
// Issues all-bank refresh (REFab) requests on a fixed tREFI cadence for one
// DDR5 channel. It shares the command bus with the ACT/RD/WR/PRE sequencer.
// Owed refreshes are postponed while the sequencer is busy. Once the
// postpone limit is reached, hold_req forces the sequencer to stop opening
// rows. The block also guarantees tRP between the last PRE and REF, and
// tRFC after REF.
//
// Ports:
//   clock             single clock for all logic
//   reset             synchronous, active-high reset
//   enable            refresh cadence enable
//   ctrl_idle         sequencer: all banks precharged, nothing in flight
//   pre_issued        one-cycle pulse when the sequencer issues PRE
//   hold_req          sequencer must not start a new ACT while high
//   ref_valid         REFab request on the shared command bus
//   ref_ready         command bus accepts ref_valid this cycle
//   refresh_active    tRFC window in progress, no ACT permitted
//   pending_count     number of owed refreshes (0..MAX_POSTPONE)
//   postpone_overflow sticky: tick arrived with pending_count==MAX_POSTPONE
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | nothing owed, or postponing while the sequencer is busy
// DRAIN  | hold off ACTs, wait for ctrl_idle and tRP since last PRE
// ISSUE  | ref_valid asserted until the bus accepts it
// TRFC   | refresh in progress, count down tRFC

module ddr5_refresh_scheduler #(
    parameter int unsigned TREFI        = 7800,
    parameter int unsigned TRFC         = 295,
    parameter int unsigned TRP          = 39,
    parameter int unsigned MAX_POSTPONE = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       ctrl_idle,
    input  logic       pre_issued,
    output logic       hold_req,
    output logic       ref_valid,
    input  logic       ref_ready,
    output logic       refresh_active,
    output logic [2:0] pending_count,
    output logic       postpone_overflow
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_TRFC  = 2'd3;

    localparam logic [CNT_W-1:0] TREFI_LAST = CNT_W'(TREFI - 1);
    localparam logic [CNT_W-1:0] TRFC_LOAD  = CNT_W'(TRFC - 1);
    localparam logic [CNT_W-1:0] TRP_LOAD   = CNT_W'(TRP - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [2:0]       MAX_PEND   = 3'(MAX_POSTPONE);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] interval_cnt;
    logic [CNT_W-1:0] trp_cnt;
    logic [CNT_W-1:0] trfc_cnt;
    logic [2:0]       pending_next;
    logic             tick;
    logic             accept;
    logic             trp_ok;
    logic             overflow_set;

    assign hold_req       = (state != S_IDLE);
    assign ref_valid      = (state == S_ISSUE);
    assign refresh_active = (state == S_TRFC);

    assign tick   = enable && (interval_cnt == TREFI_LAST);
    assign accept = (state == S_ISSUE) && ref_ready;
    // A PRE in the current cycle restarts tRP, so it blocks REF immediately.
    assign trp_ok = (trp_cnt == CNT_ZERO) && !pre_issued;

    always_ff @(posedge clock) begin
        if (reset) begin
            interval_cnt <= '0;
        end else if (!enable || tick) begin
            interval_cnt <= '0;
        end else begin
            interval_cnt <= interval_cnt + 1'b1;
        end
    end

    // A tick and an accept on the same edge cancel out.
    always_comb begin
        pending_next = pending_count;
        overflow_set = 1'b0;
        if (tick && !accept) begin
            if (pending_count == MAX_PEND) begin
                overflow_set = 1'b1;
            end else begin
                pending_next = pending_count + 3'd1;
            end
        end else if (accept && !tick) begin
            if (pending_count != 3'd0) begin
                pending_next = pending_count - 3'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_count     <= 3'd0;
            postpone_overflow <= 1'b0;
        end else begin
            pending_count <= pending_next;
            if (overflow_set) begin
                postpone_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            trp_cnt <= '0;
        end else if (pre_issued) begin
            trp_cnt <= TRP_LOAD;
        end else if (trp_cnt != CNT_ZERO) begin
            trp_cnt <= trp_cnt - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            trfc_cnt <= '0;
        end else if (accept) begin
            trfc_cnt <= TRFC_LOAD;
        end else if (state == S_TRFC && trfc_cnt != CNT_ZERO) begin
            trfc_cnt <= trfc_cnt - 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (enable && pending_count != 3'd0 &&
                    (ctrl_idle || pending_count == MAX_PEND)) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (ctrl_idle && trp_ok) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (accept) begin
                    state_next = S_TRFC;
                end
            end
            S_TRFC: begin
                // With enable low the running refresh finishes and the block
                // parks in IDLE; owed refreshes resume once enable returns.
                if (trfc_cnt == CNT_ZERO) begin
                    if (pending_next != 3'd0 && enable) begin
                        state_next = S_DRAIN;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

endmodule

// File: tb/tb_ddr5_refresh_scheduler.sv
// tb_ddr5_refresh_scheduler
//
// Directed bench for ddr5_refresh_scheduler with TREFI=100, TRFC=20, TRP=5,
// MAX_POSTPONE=4. Table rows give inputs, a number of clock edges to run,
// and the outputs expected afterwards. Hand-written sequences cover the
// multi-cycle timing cases. The cycle counter cyc counts edges since reset
// release. Outputs are sampled 1 time unit after each rising edge.

module tb_ddr5_refresh_scheduler;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       ctrl_idle;
    logic       pre_issued;
    logic       hold_req;
    logic       ref_valid;
    logic       ref_ready;
    logic       refresh_active;
    logic [2:0] pending_count;
    logic       postpone_overflow;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    ddr5_refresh_scheduler #(
        .TREFI(100), .TRFC(20), .TRP(5), .MAX_POSTPONE(4), .CNT_W(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .ctrl_idle(ctrl_idle),
        .pre_issued(pre_issued),
        .hold_req(hold_req),
        .ref_valid(ref_valid),
        .ref_ready(ref_ready),
        .refresh_active(refresh_active),
        .pending_count(pending_count),
        .postpone_overflow(postpone_overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit rst;
        bit en;
        bit idle;
        bit pre;
        bit rdy;
        int n;
        bit h;
        bit v;
        bit a;
        int p;
        bit o;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit en, bit idle, bit pre, bit rdy, int n,
                                bit h, bit v, bit a, int p, bit o);
        vec_t r;
        r.rst = rst; r.en = en; r.idle = idle; r.pre = pre; r.rdy = rdy; r.n = n;
        r.h = h; r.v = v; r.a = a; r.p = p; r.o = o;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic check_outs(input string tag, input vec_t r);
        check({tag, ".hold_req"},          32'(hold_req),          32'(r.h));
        check({tag, ".ref_valid"},         32'(ref_valid),         32'(r.v));
        check({tag, ".refresh_active"},    32'(refresh_active),    32'(r.a));
        check({tag, ".pending_count"},     32'(pending_count),     32'(r.p));
        check({tag, ".postpone_overflow"}, 32'(postpone_overflow), 32'(r.o));
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            enable     = tbl[i].en;
            ctrl_idle  = tbl[i].idle;
            pre_issued = tbl[i].pre;
            ref_ready  = tbl[i].rdy;
            if (tbl[i].rst) begin
                reset = 1'b1;
                repeat (tbl[i].n) step();
                check_outs($sformatf("row%0d", i), tbl[i]);
                reset = 1'b0;
                cyc   = 0;
            end else begin
                repeat (tbl[i].n) step();
                check_outs($sformatf("row%0d", i), tbl[i]);
            end
        end
    endtask

    initial begin
        int t2_lo;
        int t2_hi;
        int acc[$];
        int first;
        int k;
        int vcount;
        int bad;
        bit done;

        reset = 1'b1; enable = 1'b0; ctrl_idle = 1'b0; pre_issued = 1'b0; ref_ready = 1'b0;

        //            rst en idle pre rdy  n   h  v  a  p  o
        // Single refresh from reset, then postpone up to the limit.
        tbl.push_back(mk(1, 1, 1, 0, 1,   3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 1,  99, 0, 0, 0, 0, 0));  // cyc 99
        tbl.push_back(mk(0, 1, 1, 0, 1,   1, 0, 0, 0, 1, 0));  // 100 tick
        tbl.push_back(mk(0, 1, 1, 0, 1,   1, 1, 0, 0, 1, 0));  // 101 DRAIN
        tbl.push_back(mk(0, 1, 1, 0, 1,   1, 1, 1, 0, 1, 0));  // 102 ISSUE
        tbl.push_back(mk(0, 1, 1, 0, 1,   1, 1, 0, 1, 0, 0));  // 103 accepted
        tbl.push_back(mk(0, 1, 1, 0, 1,  19, 1, 0, 1, 0, 0));  // 122 last tRFC
        tbl.push_back(mk(0, 1, 1, 0, 1,   1, 0, 0, 0, 0, 0));  // 123 IDLE
        tbl.push_back(mk(0, 1, 0, 0, 1,  76, 0, 0, 0, 0, 0));  // 199
        tbl.push_back(mk(0, 1, 0, 0, 1,   1, 0, 0, 0, 1, 0));  // 200
        tbl.push_back(mk(0, 1, 0, 0, 1, 100, 0, 0, 0, 2, 0));  // 300
        tbl.push_back(mk(0, 1, 0, 0, 1, 100, 0, 0, 0, 3, 0));  // 400
        tbl.push_back(mk(0, 1, 0, 0, 1,  99, 0, 0, 0, 3, 0));  // 499
        tbl.push_back(mk(0, 1, 0, 0, 1,   1, 0, 0, 0, 4, 0));  // 500
        tbl.push_back(mk(0, 1, 0, 0, 1,   1, 1, 0, 0, 4, 0));  // 501 forced DRAIN
        tbl.push_back(mk(0, 1, 0, 0, 1,  10, 1, 0, 0, 4, 0));  // 511 still waiting
        t2_lo = tbl.size();
        // Postpone overflow, then reset clears it.
        tbl.push_back(mk(1, 1, 0, 0, 1,   2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 499, 1, 0, 0, 4, 0));  // 499
        tbl.push_back(mk(0, 1, 0, 0, 1,   1, 1, 0, 0, 4, 1));  // 500 5th tick
        tbl.push_back(mk(0, 1, 0, 0, 1,  20, 1, 0, 0, 4, 1));  // 520
        tbl.push_back(mk(1, 1, 0, 0, 1,   1, 0, 0, 0, 0, 0));
        t2_hi = tbl.size() - 1;

        apply_rows(0, t2_lo - 1);

        // Four owed refreshes drain back to back, 22 cycles apart.
        ctrl_idle = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step();
            if (ref_valid && ref_ready) acc.push_back(cyc + 1);
            if (!hold_req) done = 1'b1;
        end
        check("drain.finished", 32'(done), 32'd1);
        check("drain.ref_count", 32'(acc.size()), 32'd4);
        if (acc.size() > 0) check("drain.first_accept", 32'(acc[0]), 32'd513);
        for (int i = 1; i < acc.size(); i++)
            check($sformatf("drain.spacing%0d", i), 32'(acc[i] - acc[i-1]), 32'd22);
        check("drain.pending_end", 32'(pending_count), 32'd0);

        // Single PRE pulse in DRAIN delays ISSUE by tRP.
        enable = 1'b1; ctrl_idle = 1'b0; ref_ready = 1'b1; pre_issued = 1'b0;
        do_reset(2);
        run_to(401);
        check("pre1.in_drain", 32'(hold_req), 32'd1);
        k = cyc;
        ctrl_idle = 1'b1; pre_issued = 1'b1;
        first = -1;
        for (int i = 0; i < 30 && first < 0; i++) begin
            step();
            pre_issued = 1'b0;
            if (ref_valid) first = cyc;
        end
        check("pre1.valid_delay", 32'(first - k), 32'd6);

        // Second PRE pulse 3 cycles later restarts the wait.
        ctrl_idle = 1'b0; pre_issued = 1'b0;
        do_reset(2);
        run_to(401);
        k = cyc;
        ctrl_idle = 1'b1; pre_issued = 1'b1;
        first = -1;
        for (int i = 0; i < 30 && first < 0; i++) begin
            step();
            pre_issued = (cyc == k + 3);
            if (ref_valid) first = cyc;
        end
        pre_issued = 1'b0;
        check("pre2.valid_delay", 32'(first - k), 32'd9);

        // ref_ready low holds ISSUE; tick coinciding with accept.
        enable = 1'b1; ctrl_idle = 1'b1; ref_ready = 1'b0;
        do_reset(2);
        run_to(102);
        check("stall.valid_start", 32'(ref_valid), 32'd1);
        vcount = 0;
        repeat (10) begin
            step();
            if (ref_valid) vcount++;
        end
        check("stall.valid_held", 32'(vcount), 32'd10);
        check("stall.pending_held", 32'(pending_count), 32'd1);
        ref_ready = 1'b1;
        step();
        check("stall.accept_pending", 32'(pending_count), 32'd0);
        check("stall.accept_active", 32'(refresh_active), 32'd1);
        ref_ready = 1'b0;
        run_to(299);
        check("tickacc.valid_before", 32'(ref_valid), 32'd1);
        check("tickacc.pending_before", 32'(pending_count), 32'd1);
        ref_ready = 1'b1;
        step();
        check("tickacc.pending_after", 32'(pending_count), 32'd1);
        check("tickacc.active_after", 32'(refresh_active), 32'd1);

        apply_rows(t2_lo, t2_hi);

        // Reset mid-tRFC, then no activity with enable low.
        enable = 1'b1; ctrl_idle = 1'b1; ref_ready = 1'b1;
        do_reset(2);
        run_to(110);
        check("midrst.active_before", 32'(refresh_active), 32'd1);
        reset = 1'b1; enable = 1'b0;
        step();
        check("midrst.outputs",
              32'({hold_req, ref_valid, refresh_active, pending_count, postpone_overflow}), 32'd0);
        reset = 1'b0;
        cyc = 0;
        bad = 0;
        repeat (300) begin
            step();
            if (hold_req || ref_valid || refresh_active || pending_count != 3'd0) bad++;
        end
        check("disabled.no_activity", 32'(bad), 32'd0);
        ctrl_idle = 1'b0; enable = 1'b1;
        repeat (99) step();
        check("reenable.pending_99", 32'(pending_count), 32'd0);
        step();
        check("reenable.pending_100", 32'(pending_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
